// File: rtl/pid_pkg.sv
// Shared constants for the PID controller: register map and derived datapath widths.
package pid_pkg;

  localparam int unsigned ADDR_KP    = 0;
  localparam int unsigned ADDR_KI    = 1;
  localparam int unsigned ADDR_KD    = 2;
  localparam int unsigned ADDR_SHIFT = 3;

  localparam int unsigned SHIFT_W = 6;

  // Signed difference of two unsigned D_WIDTH values needs one extra bit.
  function automatic int unsigned err_w(input int unsigned d_width);
    return d_width + 1;
  endfunction

  // Wide enough that KP*e + KI*integ + KD*deriv can never overflow.
  function automatic int unsigned sum_w(input int unsigned d_width, input int unsigned acc_width);
    return acc_width + d_width + 3;
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Signed saturating resize: clamps a two's complement value of IN_W bits into OUT_W bits.
module pid_sat #(
  parameter int unsigned IN_W  = 17,
  parameter int unsigned OUT_W = 16
) (
  input  logic [IN_W-1:0]  data_i,
  output logic [OUT_W-1:0] data_o
);

  // Value fits exactly when every bit from the output sign bit upward is identical.
  logic [IN_W-OUT_W:0] top_bits;
  assign top_bits = data_i[IN_W-1:OUT_W-1];

  always_comb begin
    data_o = data_i[OUT_W-1:0];
    if (!(&top_bits) && (|top_bits)) begin
      if (data_i[IN_W-1]) begin
        data_o = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        data_o = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/pid_controller.sv
// Two-stage pipelined PID controller with a write-only gain/shift register file
// and saturated signed output.
module pid_controller
  import pid_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH = 2 * D_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               write_enable,
  input  logic [D_WIDTH-1:0] reg_addr,
  input  logic [D_WIDTH-1:0] reg_data,
  input  logic [D_WIDTH-1:0] target,
  input  logic [D_WIDTH-1:0] measurement,
  output logic [D_WIDTH-1:0] out
);

  localparam int unsigned ERR_W = err_w(D_WIDTH);
  localparam int unsigned SUM_W = sum_w(D_WIDTH, ACC_WIDTH);

  // Config regs survive reset; they only power up to zero.
  logic [D_WIDTH-1:0] kp_q    = '0;
  logic [D_WIDTH-1:0] ki_q    = '0;
  logic [D_WIDTH-1:0] kd_q    = '0;
  logic [SHIFT_W-1:0] shift_q = '0;

  always_ff @(posedge clock) begin
    if (!write_enable) begin
      if (reg_addr == D_WIDTH'(ADDR_KP)) begin
        kp_q <= reg_data;
      end else if (reg_addr == D_WIDTH'(ADDR_KI)) begin
        ki_q <= reg_data;
      end else if (reg_addr == D_WIDTH'(ADDR_KD)) begin
        kd_q <= reg_data;
      end else if (reg_addr == D_WIDTH'(ADDR_SHIFT)) begin
        shift_q <= reg_data[SHIFT_W-1:0];
      end
    end
  end

  // Stage 1: error, integral, derivative.
  logic [ERR_W-1:0]     err;
  logic [ERR_W-1:0]     err_q;
  logic [ERR_W-1:0]     err_prev_q;
  logic [ERR_W:0]       deriv_d;
  logic [ERR_W:0]       deriv_q;
  logic [ACC_WIDTH:0]   integ_sum;
  logic [ACC_WIDTH-1:0] integ_sat;
  logic [ACC_WIDTH-1:0] integ_q;

  assign err       = {1'b0, target} - {1'b0, measurement};
  assign deriv_d   = {err[ERR_W-1], err} - {err_prev_q[ERR_W-1], err_prev_q};
  assign integ_sum = {integ_q[ACC_WIDTH-1], integ_q}
                   + {{(ACC_WIDTH + 1 - ERR_W){err[ERR_W-1]}}, err};

  pid_sat #(
    .IN_W (ACC_WIDTH + 1),
    .OUT_W(ACC_WIDTH)
  ) u_integ_sat (
    .data_i(integ_sum),
    .data_o(integ_sat)
  );

  // Stage 2: multiply-accumulate at full width, then arithmetic shift and clamp.
  logic signed [SUM_W-1:0] kp_x, ki_x, kd_x;
  logic signed [SUM_W-1:0] err_x, integ_x, deriv_x;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sum_shr;
  logic [D_WIDTH-1:0]      out_d;
  logic [D_WIDTH-1:0]      out_q;

  assign kp_x    = {{(SUM_W - D_WIDTH){1'b0}}, kp_q};
  assign ki_x    = {{(SUM_W - D_WIDTH){1'b0}}, ki_q};
  assign kd_x    = {{(SUM_W - D_WIDTH){1'b0}}, kd_q};
  assign err_x   = {{(SUM_W - ERR_W){err_q[ERR_W-1]}}, err_q};
  assign integ_x = {{(SUM_W - ACC_WIDTH){integ_q[ACC_WIDTH-1]}}, integ_q};
  assign deriv_x = {{(SUM_W - ERR_W - 1){deriv_q[ERR_W]}}, deriv_q};

  assign sum     = (kp_x * err_x) + (ki_x * integ_x) + (kd_x * deriv_x);
  assign sum_shr = sum >>> shift_q;

  pid_sat #(
    .IN_W (SUM_W),
    .OUT_W(D_WIDTH)
  ) u_out_sat (
    .data_i(sum_shr),
    .data_o(out_d)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      err_q      <= '0;
      err_prev_q <= '0;
      deriv_q    <= '0;
      integ_q    <= '0;
      out_q      <= '0;
    end else begin
      err_q      <= err;
      err_prev_q <= err;
      deriv_q    <= deriv_d;
      integ_q    <= integ_sat;
      out_q      <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pid_controller.sv
// Directed bench for pid_controller: hand-computed output sequences for P, I, D,
// saturation, shift, reset and register-write behaviour.
module tb_pid_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enable;
  logic [15:0] reg_addr;
  logic [15:0] reg_data;
  logic [15:0] target;
  logic [15:0] measurement;
  logic [15:0] out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  pid_controller #(
    .D_WIDTH  (16),
    .ACC_WIDTH(32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .write_enable(write_enable),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .target      (target),
    .measurement (measurement),
    .out         (out)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    write_enable = 1'b0;
    reg_addr     = addr;
    reg_data     = data;
    step();
    write_enable = 1'b1;
  endtask

  task automatic set_gains(input logic [15:0] kp, input logic [15:0] ki,
                           input logic [15:0] kd, input logic [15:0] sh);
    wr(16'd0, kp);
    wr(16'd1, ki);
    wr(16'd2, kd);
    wr(16'd3, sh);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [15:0] pid_seq [5];

  initial begin
    reset        = 1'b0;
    write_enable = 1'b1;
    reg_addr     = '0;
    reg_data     = '0;
    target       = 16'd50;
    measurement  = 16'd0;
    step(3);
    check_eq("rst_out", out, 16'h0000);

    // Gains power up to zero.
    reset = 1'b1;
    step(3);
    check_eq("pwrup_zero", out, 16'h0000);

    // Writes accepted while reset is held.
    reset = 1'b0;
    set_gains(16'd1, 16'd0, 16'd0, 16'd0);
    reset = 1'b1;
    step();
    check_eq("p_latency", out, 16'h0000);
    step();
    check_eq("p_only", out, 16'h0032);

    target      = 16'd0;
    measurement = 16'd50;
    step();
    check_eq("p_pipe_hold", out, 16'h0032);
    step();
    check_eq("p_neg", out, 16'hFFCE);

    wr(16'd0, 16'hFFFF);
    target      = 16'd50;
    measurement = 16'd0;
    step(2);
    check_eq("p_sat_pos", out, 16'h7FFF);
    target      = 16'd0;
    measurement = 16'd50;
    step(2);
    check_eq("p_sat_neg", out, 16'h8000);

    // Arithmetic shift.
    wr(16'd0, 16'd1);
    wr(16'd3, 16'd2);
    target      = 16'd200;
    measurement = 16'd0;
    step(2);
    check_eq("shr_pos", out, 16'h0032);
    target      = 16'd0;
    measurement = 16'd3;
    step(2);
    check_eq("shr_neg", out, 16'hFFFF);
    wr(16'd3, 16'd63);
    target      = 16'd200;
    measurement = 16'd0;
    step(2);
    check_eq("shr_big_pos", out, 16'h0000);
    target      = 16'd0;
    measurement = 16'd3;
    step(2);
    check_eq("shr_big_neg", out, 16'hFFFF);

    // Ignored writes: strobe high, out-of-range addresses, upper SHIFT bits.
    wr(16'd3, 16'd0);
    target       = 16'd50;
    measurement  = 16'd0;
    write_enable = 1'b1;
    reg_addr     = 16'd0;
    reg_data     = 16'd5;
    step();
    wr(16'd7, 16'd5);
    wr(16'h0100, 16'd5);
    step(2);
    check_eq("no_write", out, 16'h0032);
    wr(16'd3, 16'hFFC0);
    step(2);
    check_eq("shift_upper", out, 16'h0032);

    // Integral ramp.
    set_gains(16'd0, 16'd1, 16'd0, 16'd0);
    pulse_reset();
    check_eq("i_rst", out, 16'h0000);
    step();
    check_eq("i_ramp0", out, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq($sformatf("i_ramp%0d", k), out, 16'(50 * k));
    end

    // Derivative impulse.
    set_gains(16'd0, 16'd0, 16'd1, 16'd0);
    pulse_reset();
    check_eq("d_rst", out, 16'h0000);
    step();
    check_eq("d_0", out, 16'h0000);
    step();
    check_eq("d_1", out, 16'h0032);
    step();
    check_eq("d_2", out, 16'h0000);
    step();
    check_eq("d_3", out, 16'h0000);

    // Full PID, mid-run reset keeps gains and restarts the integral.
    set_gains(16'd14, 16'd13, 16'd13, 16'd13);
    target      = 16'd1000;
    measurement = 16'd0;
    pid_seq[0] = 16'd0;
    pid_seq[1] = 16'd4;
    pid_seq[2] = 16'd4;
    pid_seq[3] = 16'd6;
    pid_seq[4] = 16'd8;
    pulse_reset();
    check_eq("pid_rst0", out, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("pid_a%0d", k), out, pid_seq[k]);
    end
    pulse_reset();
    check_eq("pid_rst1", out, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq($sformatf("pid_b%0d", k), out, pid_seq[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
